// File: rtl/sha256_multiblock_core.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | sha256_multiblock_core: SHA-224/256 compression with chaining across pre-padded 512b blocks |
// | Rev 1.0                                                                                    |
// +--------------------------------------------------------------------------------------------+
module sha256_multiblock_core #(
  parameter int UNROLL    = 1,
  parameter int MSG_SIZ   = 512,
  parameter int WRD_SIZE  = 32,
  parameter int HASH_SIZE = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_blk_valid,
  output logic                 o_blk_ready,
  input  logic [MSG_SIZ-1:0]   i_blk,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic                 i_mode,
  output logic                 o_digest_valid,
  input  logic                 i_digest_ready,
  output logic [HASH_SIZE-1:0] o_digest,
  output logic                 o_busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha256_multiblock_core: UNROLL must be 1, 2 or 4");
  end

  typedef logic [WRD_SIZE-1:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [5:0]   LAST_CNT = 6'(64 - UNROLL);

  localparam word_t K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WRD_SIZE - n));
  endfunction
  function automatic word_t bsig0(input word_t x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic word_t bsig1(input word_t x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic word_t ssig0(input word_t x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic word_t ssig1(input word_t x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  state_t         state, state_next;
  word_t          h    [8];
  word_t          v    [8];
  word_t          w    [16];
  word_t          nv   [8];
  word_t          nw   [16];
  word_t          t1, t2, wn;
  logic [5:0]     cnt;
  logic           mode, last;
  logic [255:0]   iv_sel;
  logic [HASH_SIZE-1:0] digest_next;

  assign iv_sel = i_mode ? IV224 : IV256;

  // Window always holds W_t..W_t+15, so expanding one word per round is valid from t=0.
  always_comb begin
    nv = v;
    nw = w;
    t1 = '0;
    t2 = '0;
    wn = '0;
    for (int k = 0; k < UNROLL; k++) begin
      t1 = nv[7] + bsig1(nv[4]) + ((nv[4] & nv[5]) ^ (~nv[4] & nv[6])) + K_ROM[cnt + 6'(k)] + nw[0];
      t2 = bsig0(nv[0]) + ((nv[0] & nv[1]) ^ (nv[0] & nv[2]) ^ (nv[1] & nv[2]));
      nv[7] = nv[6]; nv[6] = nv[5]; nv[5] = nv[4]; nv[4] = nv[3] + t1;
      nv[3] = nv[2]; nv[2] = nv[1]; nv[1] = nv[0]; nv[0] = t1 + t2;
      wn = ssig1(nw[14]) + nw[9] + ssig0(nw[1]) + nw[0];
      for (int j = 0; j < 15; j++) nw[j] = nw[j+1];
      nw[15] = wn;
    end
  end

  always_comb begin
    digest_next = '0;
    for (int j = 0; j < 8; j++) digest_next[HASH_SIZE-1-WRD_SIZE*j -: WRD_SIZE] = h[j] + v[j];
    if (mode) digest_next[WRD_SIZE-1:0] = '0;
  end

  always_comb begin
    state_next  = state;
    o_blk_ready = (state == IDLE);
    o_busy      = (state != IDLE);
    case (state)
      IDLE:    if (i_blk_valid) state_next = ROUND;
      ROUND:   if (cnt == LAST_CNT) state_next = FINAL;
      FINAL:   state_next = last ? DONE : IDLE;
      DONE:    if (i_digest_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      mode           <= 1'b0;
      last           <= 1'b0;
      o_digest_valid <= 1'b0;
      o_digest       <= '0;
      for (int j = 0; j < 8; j++) begin
        h[j] <= IV256[255-32*j -: 32];
        v[j] <= '0;
      end
      for (int j = 0; j < 16; j++) w[j] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (i_blk_valid) begin
          for (int j = 0; j < 16; j++) w[j] <= i_blk[MSG_SIZ-1-WRD_SIZE*j -: WRD_SIZE];
          for (int j = 0; j < 8; j++) begin
            if (i_first) begin
              h[j] <= iv_sel[255-32*j -: 32];
              v[j] <= iv_sel[255-32*j -: 32];
            end else begin
              v[j] <= h[j];
            end
          end
          if (i_first) mode <= i_mode;
          last <= i_last;
          cnt  <= '0;
        end
        ROUND: begin
          v   <= nv;
          w   <= nw;
          cnt <= cnt + 6'(UNROLL);
        end
        FINAL: begin
          for (int j = 0; j < 8; j++) h[j] <= h[j] + v[j];
          if (last) begin
            o_digest       <= digest_next;
            o_digest_valid <= 1'b1;
          end
        end
        DONE: if (i_digest_ready) o_digest_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_multiblock_core.sv
`default_nettype none
// Directed-vector bench for sha256_multiblock_core at UNROLL 1, 2 and 4.
module tb_sha256_multiblock_core;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h00000000}}, 32'h000001c0};
  localparam logic [255:0] ABC256  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC224  = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] TWO256  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [511:0] blk = '0;
  logic         first = 1'b0, last = 1'b0, mode = 1'b0, digest_ready = 1'b0;
  logic         valid1 = 1'b0, valid2 = 1'b0, valid4 = 1'b0;
  logic         ready1, ready2, ready4, dv1, dv2, dv4, busy1, busy2, busy4;
  logic [255:0] dig1, dig2, dig4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_multiblock_core #(.UNROLL(1)) u_u1 (
    .clk(clk), .reset_n(reset_n), .i_blk_valid(valid1), .o_blk_ready(ready1), .i_blk(blk),
    .i_first(first), .i_last(last), .i_mode(mode), .o_digest_valid(dv1),
    .i_digest_ready(digest_ready), .o_digest(dig1), .o_busy(busy1));
  sha256_multiblock_core #(.UNROLL(2)) u_u2 (
    .clk(clk), .reset_n(reset_n), .i_blk_valid(valid2), .o_blk_ready(ready2), .i_blk(blk),
    .i_first(first), .i_last(last), .i_mode(mode), .o_digest_valid(dv2),
    .i_digest_ready(digest_ready), .o_digest(dig2), .o_busy(busy2));
  sha256_multiblock_core #(.UNROLL(4)) u_u4 (
    .clk(clk), .reset_n(reset_n), .i_blk_valid(valid4), .o_blk_ready(ready4), .i_blk(blk),
    .i_first(first), .i_last(last), .i_mode(mode), .o_digest_valid(dv4),
    .i_digest_ready(digest_ready), .o_digest(dig4), .o_busy(busy4));

  // Presents one block to the selected instance; returns 1ns after its accept edge.
  task automatic send(input int which, input logic [511:0] b, input logic f, input logic l, input logic m);
    @(negedge clk);
    blk = b; first = f; last = l; mode = m;
    if (which == 1) valid1 = 1'b1;
    else if (which == 2) valid2 = 1'b1;
    else valid4 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0; valid2 = 1'b0; valid4 = 1'b0;
  endtask

  task automatic wait_digest(input int which, output int cyc);
    logic seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      seen = (which == 1) ? dv1 : (which == 2) ? dv2 : dv4;
    end
  endtask

  task automatic take_digest();
    @(negedge clk);
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready1); end
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b want 0", dv1); end
    checks++; if (dig1 !== 256'h0) begin errors++; $display("FAIL reset_digest got %h want 0", dig1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
  endtask

  task automatic test_abc256();
    int cyc;
    send(1, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(1, cyc);
    checks++; if (cyc != 65) begin errors++; $display("FAIL abc_latency got %0d want 65", cyc); end
    checks++; if (dig1 !== ABC256) begin errors++; $display("FAIL abc_digest got %h want %h", dig1, ABC256); end
    checks++; if (ready1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL abc_done_flags got ready=%b busy=%b want 0 1", ready1, busy1); end
    take_digest();
    checks++; if (dv1 !== 1'b0 || ready1 !== 1'b1) begin
      errors++; $display("FAIL abc_release got dv=%b ready=%b want 0 1", dv1, ready1); end
  endtask

  task automatic test_abc224();
    int cyc;
    send(1, ABC_BLK, 1'b1, 1'b1, 1'b1);
    wait_digest(1, cyc);
    checks++; if (cyc != 65) begin errors++; $display("FAIL abc224_latency got %0d want 65", cyc); end
    checks++; if (dig1 !== ABC224) begin errors++; $display("FAIL abc224_digest got %h want %h", dig1, ABC224); end
    take_digest();
  endtask

  task automatic test_two_block();
    int cyc;
    send(1, TWO_B1, 1'b1, 1'b0, 1'b0);
    cyc = 0;
    while (ready1 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc != 65) begin errors++; $display("FAIL two_gap got %0d want 65", cyc); end
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL two_mid_dvalid got %b want 0", dv1); end
    send(1, TWO_B2, 1'b0, 1'b1, 1'b1);
    wait_digest(1, cyc);
    checks++; if (cyc != 65) begin errors++; $display("FAIL two_latency got %0d want 65", cyc); end
    checks++; if (dig1 !== TWO256) begin errors++; $display("FAIL two_digest got %h want %h", dig1, TWO256); end
    take_digest();
  endtask

  task automatic test_unroll();
    int cyc;
    send(2, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(2, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL u2_latency got %0d want 33", cyc); end
    checks++; if (dig2 !== ABC256) begin errors++; $display("FAIL u2_digest got %h want %h", dig2, ABC256); end
    take_digest();
    send(4, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(4, cyc);
    checks++; if (cyc != 17) begin errors++; $display("FAIL u4_latency got %0d want 17", cyc); end
    checks++; if (dig4 !== ABC256) begin errors++; $display("FAIL u4_digest got %h want %h", dig4, ABC256); end
    take_digest();
    checks++; if (dv4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL u4_release got dv=%b busy=%b want 0 0", dv4, busy4); end
  endtask

  task automatic test_hold();
    int cyc;
    send(1, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(1, cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      blk = TWO_B1; first = 1'b1; last = 1'b1;
      valid1 = (i % 2 == 0);
      @(posedge clk); #1;
      checks++; if (dv1 !== 1'b1 || ready1 !== 1'b0 || dig1 !== ABC256) begin
        errors++; $display("FAIL hold_%0d got dv=%b ready=%b dig=%h want 1 0 %h", i, dv1, ready1, dig1, ABC256); end
    end
    valid1 = 1'b0;
    take_digest();
    send(1, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(1, cyc);
    checks++; if (cyc != 65 || dig1 !== ABC256) begin
      errors++; $display("FAIL hold_next got lat=%0d dig=%h want 65 %h", cyc, dig1, ABC256); end
    take_digest();
  endtask

  task automatic test_reset_mid();
    int cyc;
    send(1, TWO_B1, 1'b1, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ready1 !== 1'b1 || dv1 !== 1'b0 || dig1 !== 256'h0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL midreset got ready=%b dv=%b dig=%h busy=%b want 1 0 0 0", ready1, dv1, dig1, busy1); end
    @(negedge clk);
    reset_n = 1'b1;
    send(1, ABC_BLK, 1'b1, 1'b1, 1'b0);
    wait_digest(1, cyc);
    checks++; if (cyc != 65 || dig1 !== ABC256) begin
      errors++; $display("FAIL midreset_next got lat=%0d dig=%h want 65 %h", cyc, dig1, ABC256); end
    take_digest();
  endtask

  initial begin
    #3;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_abc256();
    test_abc224();
    test_two_block();
    test_unroll();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
